// File: rtl/v_issue_pkg.sv
// Shared types for the vector issue queue: the queued entry layout and the
// fence-drain state machine encoding.
package v_issue_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } v_entry_t;

  localparam int unsigned ENTRY_W = $bits(v_entry_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fence_state_e;

endpackage

// File: rtl/v_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on rdata
// whenever the FIFO is not empty, and rdata reads as zero when it is empty.
module v_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the write even if the head leaves in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;
  assign rdata = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; validity comes from cnt alone, and
  // rdata is masked while empty so stale words never reach the outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/v_issue_queue.sv
// Issue queue between the scalar core and the vector core: buffers vector
// instructions, tracks outstanding loads/stores and implements fence draining.
module v_issue_queue
  import v_issue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 15
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid_i,
  input  logic [31:0]                s_instr_i,
  input  logic [31:0]                s_rs1_i,
  input  logic [31:0]                s_rs2_i,
  input  logic                       s_is_load_i,
  input  logic                       s_is_store_i,
  output logic                       vector_stall_o,
  output logic                       v_valid_o,
  output logic [31:0]                v_instr_o,
  output logic [31:0]                v_rs1_o,
  output logic [31:0]                v_rs2_o,
  input  logic                       v_ready_i,
  input  logic                       v_load_done_i,
  input  logic                       v_store_done_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
  output logic                       all_v_loads_executed_o,
  output logic                       all_v_stores_executed_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned OC_W = $clog2(MAX_OUTST+1);

  fence_state_e    state;
  logic            fence_done_q;
  logic [OC_W-1:0] load_cnt;
  logic [OC_W-1:0] store_cnt;

  v_entry_t        push_entry;
  v_entry_t        head_entry;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            load_inc;
  logic            load_dec;
  logic            store_inc;
  logic            store_dec;
  logic            load_sat;
  logic            store_sat;

  assign load_sat  = (load_cnt  == OC_W'(MAX_OUTST));
  assign store_sat = (store_cnt == OC_W'(MAX_OUTST));

  assign vector_stall_o = s_valid_i &&
                          (fifo_full ||
                           (s_is_load_i  && load_sat) ||
                           (s_is_store_i && store_sat) ||
                           (state != IDLE));

  assign push = s_valid_i && !vector_stall_o;
  assign pop  = v_valid_o && v_ready_i;

  assign push_entry = '{instr: s_instr_i, rs1: s_rs1_i, rs2: s_rs2_i};

  v_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count_o)
  );

  assign v_valid_o = !fifo_empty;
  assign v_instr_o = head_entry.instr;
  assign v_rs1_o   = head_entry.rs1;
  assign v_rs2_o   = head_entry.rs2;

  // Done pulses arriving with the counter already at zero are dropped.
  assign load_inc  = push && s_is_load_i;
  assign load_dec  = v_load_done_i && (load_cnt != '0);
  assign store_inc = push && s_is_store_i;
  assign store_dec = v_store_done_i && (store_cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      case ({load_inc, load_dec})
        2'b10:   load_cnt <= load_cnt + 1'b1;
        2'b01:   load_cnt <= load_cnt - 1'b1;
        default: load_cnt <= load_cnt;
      endcase
      case ({store_inc, store_dec})
        2'b10:   store_cnt <= store_cnt + 1'b1;
        2'b01:   store_cnt <= store_cnt - 1'b1;
        default: store_cnt <= store_cnt;
      endcase
    end
  end

  assign all_v_loads_executed_o  = (load_cnt == '0);
  assign all_v_stores_executed_o = (store_cnt == '0);

  // Fence: stop accepting, wait until nothing is queued or outstanding, then
  // pulse fence_done_o for exactly one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      fence_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fence_done_q <= 1'b0;
          if (fence_i) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && (load_cnt == '0) && (store_cnt == '0)) begin
            state        <= DONE;
            fence_done_q <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          fence_done_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          fence_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign fence_done_o = fence_done_q;

endmodule

// File: tb/tb_v_issue_queue.sv
// Self-checking bench for v_issue_queue: directed scenarios plus random traffic
// compared against a queue-and-counter reference model.
module tb_v_issue_queue;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 15;

  logic        clk;
  logic        rstn;
  logic        s_valid_i;
  logic [31:0] s_instr_i;
  logic [31:0] s_rs1_i;
  logic [31:0] s_rs2_i;
  logic        s_is_load_i;
  logic        s_is_store_i;
  logic        vector_stall_o;
  logic        v_valid_o;
  logic [31:0] v_instr_o;
  logic [31:0] v_rs1_o;
  logic [31:0] v_rs2_o;
  logic        v_ready_i;
  logic        v_load_done_i;
  logic        v_store_done_i;
  logic        fence_i;
  logic        fence_done_o;
  logic        all_v_loads_executed_o;
  logic        all_v_stores_executed_o;
  logic [2:0]  count_o;

  v_issue_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .s_valid_i               (s_valid_i),
    .s_instr_i               (s_instr_i),
    .s_rs1_i                 (s_rs1_i),
    .s_rs2_i                 (s_rs2_i),
    .s_is_load_i             (s_is_load_i),
    .s_is_store_i            (s_is_store_i),
    .vector_stall_o          (vector_stall_o),
    .v_valid_o               (v_valid_o),
    .v_instr_o               (v_instr_o),
    .v_rs1_o                 (v_rs1_o),
    .v_rs2_o                 (v_rs2_o),
    .v_ready_i               (v_ready_i),
    .v_load_done_i           (v_load_done_i),
    .v_store_done_i          (v_store_done_i),
    .fence_i                 (fence_i),
    .fence_done_o            (fence_done_o),
    .all_v_loads_executed_o  (all_v_loads_executed_o),
    .all_v_stores_executed_o (all_v_stores_executed_o),
    .count_o                 (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued entries as {instr, rs1, rs2}, plain integer
  // counters, and fence phase 0 = idle, 1 = draining, 2 = done.
  logic [95:0] mq[$];
  int          m_ld;
  int          m_st;
  int          m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic exp_stall);
    logic [95:0] head;
    head = (mq.size() != 0) ? mq[0] : 96'd0;
    check("stall",      32'(vector_stall_o), 32'(exp_stall));
    check("v_valid",    32'(v_valid_o), 32'(mq.size() != 0));
    check("v_instr",    v_instr_o, head[95:64]);
    check("v_rs1",      v_rs1_o, head[63:32]);
    check("v_rs2",      v_rs2_o, head[31:0]);
    check("count",      32'(count_o), 32'(mq.size()));
    check("all_loads",  32'(all_v_loads_executed_o), 32'(m_ld == 0));
    check("all_stores", 32'(all_v_stores_executed_o), 32'(m_st == 0));
    check("fence_done", 32'(fence_done_o), 32'(m_phase == 2));
  endtask

  // Check outputs mid-cycle, cross one rising edge, then advance the model.
  task automatic tick();
    logic exp_stall;
    logic do_pop;
    logic do_push;
    int   n;
    #1;
    n = mq.size();
    exp_stall = s_valid_i && (n == DEPTH ||
                              (s_is_load_i && m_ld == MAX_OUTST) ||
                              (s_is_store_i && m_st == MAX_OUTST) ||
                              m_phase != 0);
    check_all(exp_stall);
    do_pop  = (n != 0) && v_ready_i;
    do_push = s_valid_i && !exp_stall;
    @(posedge clk);
    #1;
    case (m_phase)
      0:       if (fence_i) m_phase = 1;
      1:       if (n == 0 && m_ld == 0 && m_st == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({s_instr_i, s_rs1_i, s_rs2_i});
    m_ld = m_ld + ((do_push && s_is_load_i) ? 1 : 0) - ((v_load_done_i && m_ld > 0) ? 1 : 0);
    m_st = m_st + ((do_push && s_is_store_i) ? 1 : 0) - ((v_store_done_i && m_st > 0) ? 1 : 0);
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic rdy,
                       input logic ldn, input logic sdn, input logic fn);
    s_valid_i      = v;
    s_instr_i      = $urandom;
    s_rs1_i        = $urandom;
    s_rs2_i        = $urandom;
    s_is_load_i    = ld;
    s_is_store_i   = st;
    v_ready_i      = rdy;
    v_load_done_i  = ldn;
    v_store_done_i = sdn;
    fence_i        = fn;
    tick();
  endtask

  task automatic idle_inputs();
    s_valid_i      = 1'b0;
    s_instr_i      = '0;
    s_rs1_i        = '0;
    s_rs2_i        = '0;
    s_is_load_i    = 1'b0;
    s_is_store_i   = 1'b0;
    v_ready_i      = 1'b0;
    v_load_done_i  = 1'b0;
    v_store_done_i = 1'b0;
    fence_i        = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    mq.delete();
    m_ld    = 0;
    m_st    = 0;
    m_phase = 0;
    #1;
    check_all(1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    #2;
    do_reset();

    // Fill to DEPTH with the consumer stalled, fifth push refused, then drain in order.
    repeat (4) drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 0, 0, 0);

    // Load counter saturation: 15 loads, 16th stalls, store still accepted,
    // a done pulse frees one slot from the following cycle.
    do_reset();
    repeat (15) drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0, 0);

    // Done pulses with nothing outstanding are ignored.
    do_reset();
    drive(0, 0, 0, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0);

    // Simultaneous push and pop at occupancy 2 across pointer wrap.
    do_reset();
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
    repeat (7) drive(1, 0, 0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);

    // Fence with two outstanding stores; extra fence pulses while draining.
    do_reset();
    repeat (2) drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

    // Fence with everything already empty still passes through one drain cycle.
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-operation while draining: entries and counts gone, no done pulse.
    do_reset();
    repeat (3) drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_issue_queue.md
V_ISSUE_QUEUE -- requirements
Module: v_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued vector instructions (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUTST, default 15, maximum outstanding vector loads and, separately, stores.
REQ-003 SHALL have ports clk, input, 1, the single clock; rstn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have inputs s_valid_i (1), s_instr_i (32), s_rs1_i (32), s_rs2_i (32), s_is_load_i (1), s_is_store_i (1), carrying an issue request from the scalar core.
REQ-005 SHALL have output vector_stall_o (1), stall to the scalar core: request not accepted this cycle.
REQ-006 SHALL have outputs v_valid_o (1), v_instr_o (32), v_rs1_o (32), v_rs2_o (32), and input v_ready_i (1), forming the dispatch to the vector core.
REQ-007 SHALL have inputs v_load_done_i and v_store_done_i (1 each), one-cycle completion pulses from the vector core.
REQ-008 SHALL have input fence_i (1), a drain request, and output fence_done_o (1), a one-cycle completion pulse.
REQ-009 SHALL have outputs all_v_loads_executed_o and all_v_stores_executed_o (1 each), plus count_o ($clog2(DEPTH+1)), the queue occupancy.

Function
REQ-010 A push SHALL occur when s_valid_i=1 and vector_stall_o=0; the pushed entry holds instr, rs1, rs2.
REQ-011 vector_stall_o SHALL be combinational: 1 when s_valid_i is high and any of: queue full; s_is_load_i with load_cnt==MAX_OUTST; s_is_store_i with store_cnt==MAX_OUTST; state!=IDLE.
REQ-012 A push while full SHALL be refused, even when a pop occurs in the same cycle.
REQ-013 The queue SHALL be first-word-fall-through: v_valid_o = not empty, and outputs show the head entry.
REQ-014 An entry pushed into an empty queue SHALL appear on v_valid_o the next cycle (latency 1).
REQ-015 A pop SHALL occur when v_valid_o=1 and v_ready_i=1; the outputs SHALL hold while v_valid_o=1 and v_ready_i=0.
REQ-016 Push and pop in the same cycle SHALL leave count_o unchanged and preserve order; the pointers wrap modulo DEPTH.
REQ-017 load_cnt SHALL increment on an accepted push with s_is_load_i and decrement on v_load_done_i; both in one cycle leaves it unchanged. store_cnt behaves the same with s_is_store_i and v_store_done_i.
REQ-018 A done pulse with its counter at 0 SHALL be ignored (no underflow); counters SHALL never exceed MAX_OUTST.
REQ-019 all_v_loads_executed_o SHALL be 1 iff load_cnt==0; all_v_stores_executed_o SHALL be 1 iff store_cnt==0 (both registered-counter derived).
REQ-020 The FSM SHALL have states IDLE, DRAIN, DONE. IDLE->DRAIN on fence_i=1. DRAIN->DONE when queue empty and both counters are 0. DONE->IDLE unconditionally after one cycle.
REQ-021 fence_done_o SHALL be 1 exactly in DONE. fence_i in DRAIN or DONE SHALL be ignored. fence_i in IDLE with everything already empty SHALL still take DRAIN (1 cycle) then DONE.
REQ-022 Dispatch and done pulses SHALL continue during DRAIN.

Reset
REQ-023 On rstn=0, immediately: the queue SHALL be empty, load_cnt=store_cnt=0 and state=IDLE, giving v_valid_o=0, fence_done_o=0, count_o=0, all_v_*_executed_o=1, and v_instr_o/v_rs1_o/v_rs2_o=0.
REQ-024 Reset mid-operation SHALL discard queued entries and outstanding counts; no fence_done_o pulse follows.

Structure
REQ-025 Package v_issue_pkg SHALL hold the entry struct typedef (instr, rs1, rs2) and the FSM state enum.
REQ-026 Storage SHALL be one sub-module, v_sync_fifo, parametrised by width and DEPTH. Counters and FSM stay in v_issue_queue.

Verification
REQ-027 Test: 4 pushes with v_ready_i=0 (DEPTH=4), then a 5th push -> vector_stall_o=1 and count_o=4. With v_ready_i=1, entries pop in order.
REQ-028 Test: 15 load pushes with no done pulses, then a 16th load -> stall. A store push in the same state -> accepted. One v_load_done_i -> the load is accepted next cycle.
REQ-029 Test: simultaneous push and pop at count_o=2 -> count_o stays 2 and the data order is preserved across pointer wrap.
REQ-030 Test: 2 stores pushed, fence_i pulsed -> pushes stall. After both pops and 2 v_store_done_i, fence_done_o=1 for one cycle, then IDLE.
REQ-031 Test: v_load_done_i with load_cnt=0 -> load_cnt stays 0 and all_v_loads_executed_o stays 1.
REQ-032 Test: rstn asserted with 3 entries and store_cnt=2 -> v_valid_o=0 and all_v_stores_executed_o=1 immediately.
